// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. It owns the fetch PC, issues one
// request at a time to instruction memory, and buffers one instruction toward
// decode. Redirects and the ebreak halt squash stale in-flight responses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req_*        request channel (valid/ready, addr == fetch_pc)
//   imem_rsp_*        response channel, one response per accepted request
//   inst_valid/inst/inst_pc/inst_ready   decode-side handshake
//   redirect_valid/redirect_pc           one-cycle redirect pulse and target
//   halt              ebreak pulse
//   halted            fetch stopped until reset
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic            kill, kill_n;
  logic            halt_pend, halt_pend_n;
  logic [31:0]     inst_n;
  logic [XLEN-1:0] inst_pc_n;
  logic [XLEN-1:0] redir_tgt;

  // Redirect targets are always halfword aligned.
  assign redir_tgt     = {redirect_pc[XLEN-1:1], 1'b0};
  assign imem_req_addr = fetch_pc;

  // State and output registers; the status outputs are decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      kill           <= 1'b0;
      halt_pend      <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= 32'd0;
      inst_pc        <= '0;
      halted         <= 1'b0;
    end else begin
      state          <= state_n;
      fetch_pc       <= fetch_pc_n;
      kill           <= kill_n;
      halt_pend      <= halt_pend_n;
      imem_req_valid <= (state_n == REQ);
      inst_valid     <= (state_n == HOLD);
      inst           <= inst_n;
      inst_pc        <= inst_pc_n;
      halted         <= (state_n == HALT);
    end
  end

  // Next-state logic. Halt outranks redirect everywhere.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    kill_n      = kill;
    halt_pend_n = halt_pend;
    inst_n      = inst;
    inst_pc_n   = inst_pc;

    unique case (state)
      IDLE: begin
        if (halt) begin
          state_n = HALT;
        end else begin
          if (redirect_valid) fetch_pc_n = redir_tgt;
          state_n = REQ;
        end
      end

      REQ: begin
        if (halt) begin
          // An accepted request still owes a response; drain it before halting.
          if (imem_req_ready) begin
            halt_pend_n = 1'b1;
            state_n     = WAIT;
          end else begin
            state_n = HALT;
          end
        end else if (redirect_valid) begin
          fetch_pc_n = redir_tgt;
          if (imem_req_ready) begin
            kill_n  = 1'b1;
            state_n = WAIT;
          end
        end else if (imem_req_ready) begin
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (halt) begin
          halt_pend_n = 1'b1;
        end else if (redirect_valid && !halt_pend) begin
          kill_n     = 1'b1;
          fetch_pc_n = redir_tgt;
        end
        if (imem_rsp_valid) begin
          if (halt || halt_pend) begin
            state_n = HALT;
          end else if (kill || redirect_valid) begin
            // Stale response: drop it and refetch from the (new) fetch_pc.
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            inst_n     = imem_rsp_data;
            inst_pc_n  = fetch_pc;
            fetch_pc_n = fetch_pc + XLEN'(4);
            state_n    = HOLD;
          end
        end
      end

      HOLD: begin
        if (halt) begin
          state_n = HALT;
        end else if (redirect_valid) begin
          // A same-cycle inst_ready still completes the handshake on decode's side.
          fetch_pc_n = redir_tgt;
          state_n    = REQ;
        end else if (inst_ready) begin
          state_n = REQ;
        end
      end

      HALT: begin
        state_n = HALT;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Responses are only legal while a request is outstanding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (state != WAIT)))
        else $error("fetch_ctrl: imem response outside WAIT");
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  localparam int unsigned XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        halted;

  fetch_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model state
  int          lat = 2;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [63:0] pend_addr = '0;

  // Per-edge event log filled by tick()
  bit          cons_v;
  logic [63:0] cons_pc;
  logic [31:0] cons_inst;
  bit          acc_v;
  logic [63:0] acc_addr;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  // One clock: log handshakes seen at this edge, then advance the memory model.
  task automatic tick();
    bit          acc;
    logic [63:0] a;
    acc       = imem_req_valid && imem_req_ready && !rst;
    a         = imem_req_addr;
    cons_v    = inst_valid && inst_ready && !rst;
    cons_pc   = inst_pc;
    cons_inst = inst;
    acc_v     = acc;
    acc_addr  = a;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (acc) begin
        pend      = 1'b1;
        pend_addr = a;
        cnt       = lat;
      end
      if (pend) begin
        if (cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;
  endtask

  task automatic apply_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    lat            = 2;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = acc_v;
    end
  endtask

  task automatic wait_cons(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = cons_v;
    end
  endtask

  task automatic wait_hold(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (inst_valid === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if ({imem_req_valid, inst_valid, halted} !== 3'b000 || imem_req_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_ctrl: req_valid=%b inst_valid=%b halted=%b addr=%h, need 0 0 0 %h",
               imem_req_valid, inst_valid, halted, imem_req_addr, RESET_PC);
    end
    total++;
    if (inst !== 32'd0 || inst_pc !== 64'd0) begin
      bad++;
      $display("FAIL reset_data: inst=%h inst_pc=%h, need 0 0", inst, inst_pc);
    end
  endtask

  task automatic test_basic();
    logic [63:0] exp;
    int n = 0;
    int last = -1;
    apply_reset();
    tick();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      bad++;
      $display("FAIL first_req: valid=%b addr=%h, need 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    exp = RESET_PC;
    for (int t = 0; t < 60 && n < 3; t++) begin
      tick();
      if (cons_v) begin
        total++;
        if (cons_pc !== exp || cons_inst !== mem_word(exp)) begin
          bad++;
          $display("FAIL basic_inst: pc=%h inst=%h, need %h %h", cons_pc, cons_inst, exp, mem_word(exp));
        end
        if (last >= 0) begin
          total++;
          if (t - last != lat + 2) begin
            bad++;
            $display("FAIL basic_rate: interval=%0d, need %0d", t - last, lat + 2);
          end
        end
        last = t;
        exp += 64'd4;
        n++;
      end
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL basic_timeout: consumed=%0d, need 3", n);
    end
  endtask

  task automatic test_hold_stall();
    bit ok;
    apply_reset();
    inst_ready = 1'b0;
    wait_hold(20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL hold_timeout: inst_valid never rose");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== mem_word(RESET_PC) || imem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: v=%b pc=%h inst=%h req=%b, need 1 %h %h 0",
                 inst_valid, inst_pc, inst, imem_req_valid, RESET_PC, mem_word(RESET_PC));
      end
    end
    inst_ready = 1'b1;
    tick();
    total++;
    if (!cons_v || cons_pc !== RESET_PC) begin
      bad++;
      $display("FAIL hold_release: consumed=%b pc=%h, need 1 %h", cons_v, cons_pc, RESET_PC);
    end
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC + 64'd4) begin
      bad++;
      $display("FAIL hold_next_req: valid=%b addr=%h, need 1 %h", imem_req_valid, imem_req_addr, RESET_PC + 64'd4);
    end
  endtask

  task automatic test_req_stall();
    apply_reset();
    imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || acc_v) begin
        bad++;
        $display("FAIL req_stall: valid=%b addr=%h acc=%b, need 1 %h 0", imem_req_valid, imem_req_addr, acc_v, RESET_PC);
      end
    end
    imem_req_ready = 1'b1;
    tick();
    total++;
    if (!acc_v || acc_addr !== RESET_PC) begin
      bad++;
      $display("FAIL req_accept: acc=%b addr=%h, need 1 %h", acc_v, acc_addr, RESET_PC);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit saw = 1'b0;
    apply_reset();
    lat = 3;
    wait_acc(10, ok);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1001;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (inst_valid === 1'b1) saw = 1'b1;
      tick();
      ok = acc_v;
    end
    total++;
    if (saw || !ok || acc_addr !== 64'h8000_1000) begin
      bad++;
      $display("FAIL redir_wait: stale_inst=%b acc=%b addr=%h, need 0 1 80001000", saw, ok, acc_addr);
    end
    wait_cons(20, ok);
    total++;
    if (!ok || cons_pc !== 64'h8000_1000 || cons_inst !== mem_word(64'h8000_1000)) begin
      bad++;
      $display("FAIL redir_wait_inst: ok=%b pc=%h inst=%h, need 1 80001000 %h", ok, cons_pc, cons_inst, mem_word(64'h8000_1000));
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    logic [63:0] tgt = 64'h0000_0000_9000_0040;
    apply_reset();
    inst_ready = 1'b0;
    wait_hold(20, ok);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    total++;
    if (!cons_v || cons_pc !== RESET_PC) begin
      bad++;
      $display("FAIL redir_hold_hs: consumed=%b pc=%h, need 1 %h", cons_v, cons_pc, RESET_PC);
    end
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== tgt || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_hold_req: valid=%b addr=%h inst_valid=%b, need 1 %h 0", imem_req_valid, imem_req_addr, inst_valid, tgt);
    end
    wait_cons(20, ok);
    total++;
    if (!ok || cons_pc !== tgt) begin
      bad++;
      $display("FAIL redir_hold_inst: ok=%b pc=%h, need 1 %h", ok, cons_pc, tgt);
    end
  endtask

  task automatic test_halt();
    bit ok;
    bit leak = 1'b0;
    apply_reset();
    lat = 4;
    wait_acc(10, ok);
    halt = 1'b1;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (cons_v || inst_valid === 1'b1) leak = 1'b1;
      ok = (halted === 1'b1);
    end
    total++;
    if (!ok || leak) begin
      bad++;
      $display("FAIL halt_enter: halted=%b inst_leak=%b, need 1 0", ok, leak);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1234;
      end
      tick();
      total++;
      if (imem_req_valid !== 1'b0 || halted !== 1'b1 || inst_valid !== 1'b0 || acc_v || imem_req_addr === 64'h1234) begin
        bad++;
        $display("FAIL halt_hold: req=%b halted=%b inst_valid=%b addr=%h, need 0 1 0 no-redirect",
                 imem_req_valid, halted, inst_valid, imem_req_addr);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (halted !== 1'b0 || imem_req_addr !== RESET_PC) begin
      bad++;
      $display("FAIL halt_reset: halted=%b addr=%h, need 0 %h", halted, imem_req_addr, RESET_PC);
    end
    tick();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      bad++;
      $display("FAIL halt_restart: valid=%b addr=%h, need 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [63:0] top = 64'hFFFF_FFFF_FFFF_FFFC;
    apply_reset();
    lat            = 1;
    redirect_valid = 1'b1;
    redirect_pc    = top;
    tick();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== top) begin
      bad++;
      $display("FAIL wrap_req: valid=%b addr=%h, need 1 %h", imem_req_valid, imem_req_addr, top);
    end
    wait_cons(20, ok);
    total++;
    if (!ok || cons_pc !== top || imem_req_addr !== 64'd0) begin
      bad++;
      $display("FAIL wrap_pc: ok=%b pc=%h next_addr=%h, need 1 %h 0", ok, cons_pc, imem_req_addr, top);
    end
  endtask

  // Random traffic against a stream model: consumed PCs run sequentially by 4,
  // restarting at the aligned target after each redirect.
  task automatic test_random();
    logic [63:0] exp = RESET_PC;
    logic [63:0] tgt;
    bit          redir;
    int          n = 0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(1, 4);
      redir          = ($urandom_range(0, 19) == 0);
      if (redir) begin
        tgt            = {$urandom, $urandom};
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end
      tick();
      if (cons_v) begin
        total++;
        if (cons_pc !== exp || cons_inst !== mem_word(exp)) begin
          bad++;
          $display("FAIL rand_inst: pc=%h inst=%h, need %h %h", cons_pc, cons_inst, exp, mem_word(exp));
        end
        exp += 64'd4;
        n++;
      end
      if (redir) exp = {tgt[63:1], 1'b0};
    end
    total++;
    if (n < 20) begin
      bad++;
      $display("FAIL rand_progress: consumed=%0d, need >=20", n);
    end
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    halt           = 1'b0;
    test_reset();
    test_basic();
    test_hold_stall();
    test_req_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_halt();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the RV64 core. Owns the fetch PC and issues requests to instruction memory over a valid/ready request channel with variable-latency responses.
- Buffers one fetched instruction toward decode under a valid/ready handshake.
- Applies redirects (jal/jalr/branch targets) and the ebreak halt, and squashes any in-flight response made stale by either.
- Sits between the next-PC logic and the decode stage.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  fetch address; equals fetch_pc.
- imem_rsp_valid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  decode-side instruction valid.
- inst  out  32  instruction to decode.
- inst_pc  out  XLEN  PC of inst.
- inst_ready  in  1  decode accepts inst.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  XLEN  redirect target.
- halt  in  1  ebreak pulse.
- halted  out  1  fetch stopped.

Behaviour:
- All outputs are driven from registers. After the first rising edge with rst=1:
  - state=IDLE, fetch_pc=RESET_PC, kill=0, halt_pend=0.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
  - imem_req_addr=RESET_PC.
- Reset taken mid-transaction abandons it. Memory must not deliver a response for a request accepted before reset.
- Redirect target: fetch_pc <= {redirect_pc[XLEN-1:1], 1'b0}; bit 0 is always cleared.
- States:
  - IDLE: no outputs asserted. Moves to REQ on the next cycle, so the first request is 1 cycle after reset release.
  - REQ: imem_req_valid=1. On imem_req_ready -> WAIT. The address must stay stable while valid && !ready, unless a redirect occurs.
  - WAIT: waits for imem_rsp_valid.
    - Response arrives with kill=0: latch inst=rsp_data, inst_pc=fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^XLEN, wraps), -> HOLD.
    - Response arrives with kill=1: discard it, clear kill, -> REQ.
  - HOLD: inst_valid=1, inst and inst_pc stable. On inst_ready -> REQ. There is no request overlap, so throughput is 1 instruction per (mem latency + 2) cycles.
  - HALT: halted=1, imem_req_valid=0, inst_valid=0. Exits only via rst. Redirect is ignored.
- Redirect (highest priority after halt):
  - In REQ, request not accepted that cycle: fetch_pc updated and the new address is presented next cycle; stay in REQ.
  - In REQ, request accepted that cycle: the old address went out. Set kill, update fetch_pc, -> WAIT.
  - In WAIT: set kill, update fetch_pc. If the response arrives in the same cycle, discard it and -> REQ.
  - In HOLD: drop the held inst (inst_valid=0 next cycle), update fetch_pc, -> REQ.
  - In HOLD with inst_ready in the same cycle: the handshake counts as consumed and the redirect still sets fetch_pc.
  - In IDLE: update fetch_pc; still -> REQ.
- Halt (priority over redirect):
  - In IDLE, HOLD, or REQ without acceptance: -> HALT next cycle. A held inst is dropped.
  - In REQ with acceptance: set halt_pend, -> WAIT.
  - In WAIT: set halt_pend.
  - WAIT with halt_pend: the response, when it arrives, is discarded, then -> HALT.
- Outstanding requests never exceed 1. A response outside WAIT is a protocol violation; assert in simulation.

Test Plan:
- Reset, memory with ready=1 and 2-cycle response latency, inst_ready=1 -> first request at 1 cycle after reset with addr 0x80000000. Then 0x80000004 and 0x80000008 are fetched; inst_pc matches each address.
- inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new request issued, imem_req_valid=0 throughout.
- imem_req_ready=0 for 3 cycles -> imem_req_valid held at 1 with constant addr. Request accepted on the 4th cycle.
- redirect_pc=0x80001001 pulsed in WAIT -> pending response discarded (inst_valid stays 0). Next request addr is 0x80001000.
- Redirect in HOLD concurrent with inst_ready=1 -> handshake counted, next request goes to the redirect target, not inst_pc+4.
- halt pulsed in WAIT -> response discarded, halted=1, no further requests for 20 cycles. A redirect during HALT has no effect; rst returns fetch to 0x80000000.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC via redirect -> after response, fetch_pc wraps to 0x0.
